scan_74138_ctrl: RTL and testbench

//  Sequencer upstream of the 74138 3-to-8 decoder. Drives its select and enable pins.

---
 rtl/scan_74138_ctrl.sv | 109 ++++++++++
 tb/tb_scan_74138_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/scan_74138_ctrl.sv
// scan_74138_ctrl: blanked channel scanner driving the select and enable pins of a 74138 decoder
//   clk_i, rst_i                   clock, synchronous active-high reset
//   start_i, stop_i, mode_i        scan control (mode 0 = continuous, 1 = single pass)
//   dwell_i                        drive cycles per channel (0 acts as 1)
//   select_a/b/c_o, g1_en_o,
//   g2a_en_n_o, g2b_en_n_o         decoder pins
//   chan_o, busy_o, done_o, wrap_o status
module scan_74138_ctrl #(
    parameter int NUM_CH    = 8,
    parameter int DWELL_W   = 8,
    parameter int BLANK_CYC = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               mode_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic               select_a_o,
    output logic               select_b_o,
    output logic               select_c_o,
    output logic               g1_en_o,
    output logic               g2a_en_n_o,
    output logic               g2b_en_n_o,
    output logic [2:0]         chan_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               wrap_o
);
    localparam int CW = DWELL_W > 4 ? DWELL_W : 4;
    // A zero-length blank still costs one disabled cycle so selects and enables never move together.
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC > 0 ? BLANK_CYC - 1 : 0);
    localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);
    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;
    state_t state, state_n;
    logic [2:0] chan_n;
    logic [CW-1:0] cnt, cnt_n, drive_last;
    logic [DWELL_W-1:0] dwell, dwell_n;
    logic mode, mode_n, stop_pend, stop_pend_n, done_n, wrap_n, stop_now, last;
    always_comb begin
        stop_now = stop_pend | stop_i;
        last = chan_o == LAST_CH;
        drive_last = dwell == '0 ? '0 : CW'(dwell - 1'b1);
        state_n = state;
        chan_n = chan_o;
        cnt_n = cnt - 1'b1;
        dwell_n = dwell;
        mode_n = mode;
        done_n = 1'b0;
        wrap_n = 1'b0;
        if (state == IDLE) begin
            cnt_n = cnt;
            if (start_i && !stop_i) begin
                state_n = BLANK;
                chan_n = '0;
                cnt_n = BLANK_LAST;
                dwell_n = dwell_i;
                mode_n = mode_i;
            end
        end else if (cnt == '0) begin
            if (state == BLANK) begin
                state_n = stop_now ? IDLE : DRIVE;
                done_n = stop_now;
                cnt_n = drive_last;
            end else if (stop_now || (mode && last)) begin
                state_n = IDLE;
                done_n = 1'b1;
            end else begin
                state_n = BLANK;
                chan_n = last ? 3'd0 : chan_o + 1'b1;
                wrap_n = last;
                cnt_n = BLANK_LAST;
                dwell_n = dwell_i;
            end
        end
        stop_pend_n = state_n != IDLE && (stop_pend || (state != IDLE && stop_i));
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            chan_o <= '0;
            cnt <= '0;
            dwell <= '0;
            mode <= 1'b0;
            stop_pend <= 1'b0;
            {select_c_o, select_b_o, select_a_o} <= 3'd0;
            g1_en_o <= 1'b0;
            g2a_en_n_o <= 1'b1;
            g2b_en_n_o <= 1'b1;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            wrap_o <= 1'b0;
        end else begin
            state <= state_n;
            chan_o <= chan_n;
            cnt <= cnt_n;
            dwell <= dwell_n;
            mode <= mode_n;
            stop_pend <= stop_pend_n;
            {select_c_o, select_b_o, select_a_o} <= state_n == IDLE ? 3'd0 : chan_n;
            g1_en_o <= state_n == DRIVE;
            g2a_en_n_o <= state_n != DRIVE;
            g2b_en_n_o <= state_n != DRIVE;
            busy_o <= state_n != IDLE;
            done_o <= done_n;
            wrap_o <= wrap_n;
        end
    end
endmodule

// File: tb/tb_scan_74138_ctrl.sv
// tb_scan_74138_ctrl: scoreboard bench for scan_74138_ctrl with a timeline reference model
module tb_scan_74138_ctrl;
    localparam int NCH = 8;
    localparam int B = 2;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, mode = 1'b0;
    logic [7:0] dwell = '0;
    logic select_a_o, select_b_o, select_c_o, g1_en_o, g2a_en_n_o, g2b_en_n_o;
    logic [2:0] chan_o;
    logic busy_o, done_o, wrap_o;

    scan_74138_ctrl #(.NUM_CH(NCH), .DWELL_W(8), .BLANK_CYC(B)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .mode_i(mode), .dwell_i(dwell),
        .select_a_o(select_a_o), .select_b_o(select_b_o), .select_c_o(select_c_o),
        .g1_en_o(g1_en_o), .g2a_en_n_o(g2a_en_n_o), .g2b_en_n_o(g2b_en_n_o),
        .chan_o(chan_o), .busy_o(busy_o), .done_o(done_o), .wrap_o(wrap_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = enabled cycle of channel ch, 1 = wrap pulse, 2 = done pulse; t = absolute cycle
    typedef struct {
        int kind;
        int ch;
        int t;
    } tok_t;
    tok_t q[$];
    int passed = 0, total = 0;
    int busy_from = 0, busy_to = 0;
    bit mon_en = 1'b0;
    logic [2:0] prev_sel = 3'd0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        logic [7:0] y, ey;
        logic [2:0] sel;
        int k;
        tok_t e;
        if (mon_en) begin
            sel = {select_c_o, select_b_o, select_a_o};
            y = (g1_en_o && !g2a_en_n_o && !g2b_en_n_o) ? ~(8'd1 << sel) : 8'hff;
            chk("busy", int'(busy_o), int'(cyc >= busy_from && cyc < busy_to));
            chk("g2a_n", int'(g2a_en_n_o), int'(!g1_en_o));
            chk("g2b_n", int'(g2b_en_n_o), int'(!g1_en_o));
            if (!busy_o) chk("idle_sel", int'(sel), 0);
            else chk("sel_chan", int'(sel), int'(chan_o));
            if (g1_en_o) chk("sel_stable", int'(sel), int'(prev_sel));
            if (g1_en_o || wrap_o || done_o) begin
                k = done_o ? 2 : (wrap_o ? 1 : 0);
                if (q.size() == 0) chk("unexpected_event", k, -1);
                else begin
                    e = q.pop_front();
                    chk("event_kind", k, e.kind);
                    chk("event_time", cyc, e.t);
                    if (k == 0) begin
                        ey = ~(8'd1 << e.ch);
                        chk("decode", int'(y), int'(ey));
                    end
                end
            end
            prev_sel = sel;
        end
    end

    // stop_t / start_t: cycle offsets (from the first cycle after the start edge) at which a
    // one-cycle stop or ignored start pulse is driven; -1 means none.
    task automatic scan(input bit m, input int dw, input int stop_t, input int start_t);
        int t0, d, base, ch, tend;
        bit fin;
        @(negedge clk);
        t0 = cyc + 1;
        d = dw < 1 ? 1 : dw;
        base = t0;
        ch = 0;
        fin = 1'b0;
        tend = t0;
        while (!fin) begin
            if (stop_t >= 0 && t0 + stop_t < base + B) begin
                q.push_back('{2, 0, base + B});
                tend = base + B;
                fin = 1'b1;
            end else begin
                for (int j = 0; j < d; j++) q.push_back('{0, ch, base + B + j});
                if ((stop_t >= 0 && t0 + stop_t < base + B + d) || (m && ch == NCH - 1)) begin
                    q.push_back('{2, 0, base + B + d});
                    tend = base + B + d;
                    fin = 1'b1;
                end else begin
                    if (ch == NCH - 1) begin
                        ch = 0;
                        q.push_back('{1, 0, base + B + d});
                    end else ch++;
                    base += B + d;
                end
            end
        end
        busy_from = t0;
        busy_to = tend;
        start = 1'b1;
        mode = m;
        dwell = 8'(dw);
        @(negedge clk);
        start = 1'b0;
        mode = 1'($urandom);
        while (cyc <= tend + 2) begin
            stop = stop_t >= 0 && cyc == t0 + stop_t;
            start = start_t >= 0 && cyc == t0 + start_t;
            @(negedge clk);
        end
        stop = 1'b0;
        start = 1'b0;
        chk("queue_drained", q.size(), 0);
        q.delete();
    endtask

    initial begin
        int d, st;
        bit m;
        repeat (3) @(negedge clk);
        chk("rst_g1", int'(g1_en_o), 0);
        chk("rst_g2a", int'(g2a_en_n_o), 1);
        chk("rst_g2b", int'(g2b_en_n_o), 1);
        chk("rst_sel", int'({select_c_o, select_b_o, select_a_o}), 0);
        chk("rst_chan", int'(chan_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_wrap", int'(wrap_o), 0);
        rst = 1'b0;
        mon_en = 1'b1;
        scan(1'b1, 3, -1, -1);
        scan(1'b0, 0, 60, 10);
        scan(1'b0, 3, 4 * (B + 3) + B + 1, -1);
        @(negedge clk);
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        repeat (4) @(negedge clk);
        chk("start_stop_idle", int'(busy_o), 0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        scan(1'b1, 1, -1, 7);
        scan(1'b1, 2, 3, -1);
        for (int i = 0; i < 8; i++) begin
            m = 1'($urandom);
            d = $urandom_range(0, 4);
            st = (m && $urandom_range(0, 1) == 0) ? -1
                 : $urandom_range(0, NCH * (B + (d < 1 ? 1 : d)) * (m ? 1 : 2) - 1);
            scan(m, d, st, $urandom_range(1, 30));
        end
        @(negedge clk);
        start = 1'b1;
        mode = 1'b0;
        dwell = 8'd3;
        busy_from = cyc + 1;
        busy_to = 1 << 30;
        for (int j = 0; j < 3; j++) q.push_back('{0, 0, cyc + 1 + B + j});
        @(negedge clk);
        start = 1'b0;
        repeat (B + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mon_en = 1'b0;
        q.delete();
        busy_to = 0;
        chk("midrst_g1", int'(g1_en_o), 0);
        chk("midrst_g2a", int'(g2a_en_n_o), 1);
        chk("midrst_g2b", int'(g2b_en_n_o), 1);
        chk("midrst_sel", int'({select_c_o, select_b_o, select_a_o}), 0);
        chk("midrst_busy", int'(busy_o), 0);
        chk("midrst_done", int'(done_o), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_done", int'(done_o), 0);
        chk("postrst_busy", int'(busy_o), 0);
        mon_en = 1'b1;
        scan(1'b1, 0, -1, -1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
